// File: rtl/in_wr_controller_fsm_if.sv
// Port bundle for the input-port write stage: upstream beat stream, data FIFO
// write side and the descriptor head presented to the read controller.
interface in_wr_controller_fsm_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int WIDTH_SEL    = 3,
  parameter int WIDTH_LENGTH = 6
);
  logic                    rx_valid;
  logic                    rx_ready;
  logic                    rx_sop;
  logic                    rx_eop;
  logic                    rx_err;
  logic [DATA_WIDTH-1:0]   rx_data;
  logic [WIDTH_SEL-1:0]    rx_dest;
  logic                    fifo_full;
  logic                    fifo_wr_en;
  logic [DATA_WIDTH-1:0]   fifo_wr_data;
  logic                    start;
  logic [WIDTH_SEL-1:0]    rx_out;
  logic [WIDTH_LENGTH-1:0] data_length;
  logic                    error_out;
  logic                    desc_ack;

  modport slave (
    input  rx_valid, rx_sop, rx_eop, rx_err, rx_data, rx_dest, fifo_full, desc_ack,
    output rx_ready, fifo_wr_en, fifo_wr_data, start, rx_out, data_length, error_out
  );

  modport master (
    output rx_valid, rx_sop, rx_eop, rx_err, rx_data, rx_dest, fifo_full, desc_ack,
    input  rx_ready, fifo_wr_en, fifo_wr_data, start, rx_out, data_length, error_out
  );
endinterface

// File: rtl/in_wr_controller_fsm.sv
// Input-port write stage: writes frame words into the data FIFO and queues a
// {dest, length, error} descriptor per frame. Runt marking: IN_WR_RUNT_DROP_EN.
module in_wr_controller_fsm #(
  parameter int DATA_WIDTH      = 32,
  parameter int PORT_NUB_TOTAL  = 8,
  parameter int DATA_LENGTH_MAX = 64,
  parameter int DESC_DEPTH      = 4
`ifdef IN_WR_RUNT_DROP_EN
  ,
  parameter int MIN_LENGTH      = 4
`endif
) (
  input logic                   clk,
  input logic                   rst_n,
  in_wr_controller_fsm_if.slave bus
);

  localparam int WIDTH_SEL    = $clog2(PORT_NUB_TOTAL);
  localparam int WIDTH_LENGTH = $clog2(DATA_LENGTH_MAX);
  localparam int PTR_WIDTH    = $clog2(DESC_DEPTH);
  localparam int ENTRY_WIDTH  = WIDTH_SEL + WIDTH_LENGTH + 1;

  localparam logic [WIDTH_LENGTH-1:0] LEN_ONE = WIDTH_LENGTH'(1);
  localparam logic [WIDTH_LENGTH-1:0] LEN_PRE = WIDTH_LENGTH'(DATA_LENGTH_MAX - 2);
`ifdef IN_WR_RUNT_DROP_EN
  localparam logic [WIDTH_LENGTH-1:0] LEN_MIN = WIDTH_LENGTH'(MIN_LENGTH);
`endif

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP,
    COMMIT
  } state_t;

  state_t                  state_q, state_d;
  logic [WIDTH_LENGTH-1:0] len_q, len_d;
  logic [WIDTH_SEL-1:0]    dest_q, dest_d;
  logic                    err_q, err_d;
  logic                    readyEn_q;

  logic [PTR_WIDTH:0]      wrPtr_q, wrPtr_d;
  logic [PTR_WIDTH:0]      rdPtr_q, rdPtr_d;
  logic [ENTRY_WIDTH-1:0]  descMem_q [DESC_DEPTH];

  logic                    rxReady;
  logic                    wrEn;
  logic                    push;
  logic                    pop;
  logic                    descEmpty;
  logic                    descFull;
  logic                    commitErr;
  logic [ENTRY_WIDTH-1:0]  headEntry;
  logic [DATA_WIDTH-1:0]   wrData;

  // Extra wrap bit distinguishes a full queue from an empty one.
  assign descEmpty = (wrPtr_q == rdPtr_q);
  assign descFull  = (wrPtr_q[PTR_WIDTH] != rdPtr_q[PTR_WIDTH]) &&
                     (wrPtr_q[PTR_WIDTH-1:0] == rdPtr_q[PTR_WIDTH-1:0]);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    dest_d  = dest_q;
    err_d   = err_q;
    rxReady = 1'b0;
    wrEn    = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // readyEn_q keeps rx_ready low while in reset and for the first cycle after it.
        rxReady = readyEn_q & ~bus.fifo_full & ~descFull;
        if (rxReady && bus.rx_valid && bus.rx_sop) begin
          wrEn    = 1'b1;
          len_d   = LEN_ONE;
          dest_d  = bus.rx_dest;
          err_d   = bus.rx_eop & bus.rx_err;
          state_d = bus.rx_eop ? COMMIT : RECV;
        end
      end
      RECV: begin
        rxReady = ~bus.fifo_full;
        if (rxReady && bus.rx_valid) begin
          wrEn  = 1'b1;
          len_d = len_q + LEN_ONE;
          err_d = err_q | bus.rx_sop | (bus.rx_eop & bus.rx_err);
          if (bus.rx_eop) begin
            state_d = COMMIT;
          end else if (len_q == LEN_PRE) begin
            err_d   = 1'b1;
            state_d = DROP;
          end
        end
      end
      DROP: begin
        rxReady = 1'b1;
        if (bus.rx_valid && bus.rx_eop) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef IN_WR_RUNT_DROP_EN
  assign commitErr = err_q | (len_q < LEN_MIN);
`else
  assign commitErr = err_q;
`endif

  assign pop     = bus.desc_ack & ~descEmpty;
  assign wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
  assign rdPtr_d = pop  ? rdPtr_q + 1'b1 : rdPtr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      dest_q    <= '0;
      err_q     <= 1'b0;
      readyEn_q <= 1'b0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      dest_q    <= dest_d;
      err_q     <= err_d;
      readyEn_q <= 1'b1;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
    end
  end

  // Entry storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      descMem_q[wrPtr_q[PTR_WIDTH-1:0]] <= {dest_q, len_q, commitErr};
    end
  end

  assign headEntry = descMem_q[rdPtr_q[PTR_WIDTH-1:0]];
  assign wrData    = bus.rx_data;

  assign bus.rx_ready     = rxReady;
  assign bus.fifo_wr_en   = wrEn;
  assign bus.fifo_wr_data = wrData;
  assign bus.start        = ~descEmpty;
  assign bus.rx_out       = descEmpty ? '0 : headEntry[ENTRY_WIDTH-1 -: WIDTH_SEL];
  assign bus.data_length  = descEmpty ? '0 : headEntry[WIDTH_LENGTH:1];
  assign bus.error_out    = descEmpty ? 1'b0 : headEntry[0];

endmodule

// File: tb/tb_in_wr_controller_fsm.sv
// Self-checking bench for in_wr_controller_fsm: directed corner cases plus
// randomized frames checked against a frame-level model of writes and descriptors.
`timescale 1ns/1ps
module tb_in_wr_controller_fsm;

  localparam int DW      = 32;
  localparam int WS      = 3;
  localparam int WL      = 6;
  localparam int MAXW    = 63;
  localparam int MIN_LEN = 4;
`ifdef IN_WR_RUNT_DROP_EN
  localparam bit RUNT_EN = 1'b1;
`else
  localparam bit RUNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [WS-1:0] dest;
    logic [WL-1:0] len;
    logic          err;
  } desc_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks     = 0;
  int failures   = 0;
  int writeCount = 0;
  int ackMode    = 0;
  int wcStart;

  logic [DW-1:0] expData[$];
  desc_t         expDesc[$];
  logic [DW-1:0] monWord;
  desc_t         monDesc;

  in_wr_controller_fsm_if #(.DATA_WIDTH(DW), .WIDTH_SEL(WS), .WIDTH_LENGTH(WL)) bus ();

  in_wr_controller_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Frame-level model: length saturates at MAXW, any anomaly sets the error flag.
  function automatic desc_t modelDesc(input int n, input logic [WS-1:0] dest, input logic rxErr, input bit midSop);
    desc_t d;
    int    len;
    len    = (n > MAXW) ? MAXW : n;
    d.dest = dest;
    d.len  = WL'(len);
    d.err  = rxErr | midSop | (n > MAXW) | (RUNT_EN && (len < MIN_LEN));
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    case (ackMode)
      0:       bus.desc_ack = 1'b0;
      1:       bus.desc_ack = 1'($urandom_range(1));
      default: bus.desc_ack = 1'b1;
    endcase
  endtask

  // Monitor: every FIFO write and every honoured pop is checked against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.fifo_wr_en === 1'b1) begin
        writeCount++;
        checkOutput("write_pending", 64'(expData.size() != 0), 64'd1);
        if (expData.size() != 0) begin
          monWord = expData.pop_front();
          checkOutput("write_data", 64'(bus.fifo_wr_data), 64'(monWord));
        end
      end
      if (bus.start === 1'b1 && bus.desc_ack === 1'b1) begin
        checkOutput("desc_pending", 64'(expDesc.size() != 0), 64'd1);
        if (expDesc.size() != 0) begin
          monDesc = expDesc.pop_front();
          checkOutput("desc_head", 64'({bus.rx_out, bus.data_length, bus.error_out}), 64'(monDesc));
        end
      end
    end
  end

  task automatic applyStimulus(input int n, input logic [WS-1:0] dest, input logic rxErr, input bit midSop,
                               input int gapPct, input int fullPct, input int fullAt);
    logic [DW-1:0] words[$];
    int  i    = 0;
    int  cyc  = 0;
    int  held = 0;
    bit  acc;
    bit  forceFull;
    for (int k = 0; k < n; k++) begin
      words.push_back($urandom);
      if (k < MAXW) expData.push_back(words[k]);
    end
    expDesc.push_back(modelDesc(n, dest, rxErr, midSop));
    while (i < n && cyc < 2000) begin
      forceFull     = (fullAt >= 0) && (i == fullAt) && (held < 3);
      bus.rx_valid  = ($urandom_range(99) >= gapPct) || forceFull;
      bus.rx_sop    = (i == 0) || (midSop && i == 2);
      bus.rx_eop    = (i == n - 1);
      bus.rx_err    = (i == n - 1) ? rxErr : 1'($urandom_range(1));
      bus.rx_data   = words[i];
      bus.rx_dest   = (i == 0) ? dest : WS'($urandom);
      bus.fifo_full = forceFull ? 1'b1 : ($urandom_range(99) < fullPct);
      @(negedge clk);
      if (forceFull) begin
        checkOutput("ready_low_fifo_full", 64'(bus.rx_ready), 64'd0);
        held++;
      end
      acc = bus.rx_valid & bus.rx_ready;
      tick();
      cyc++;
      if (acc) i++;
    end
    checkOutput("frame_beats_accepted", 64'(i), 64'(n));
    bus.rx_valid  = 1'b0;
    bus.rx_sop    = 1'b0;
    bus.rx_eop    = 1'b0;
    bus.rx_err    = 1'b0;
    bus.fifo_full = 1'b0;
  endtask

  task automatic waitStart();
    int cyc = 0;
    @(negedge clk);
    while (bus.start !== 1'b1 && cyc < 50) begin
      tick();
      @(negedge clk);
      cyc++;
    end
    checkOutput("start_seen", 64'(bus.start), 64'd1);
  endtask

  task automatic drain();
    int cyc = 0;
    ackMode = 2;
    while (expDesc.size() != 0 && cyc < 300) begin
      tick();
      cyc++;
    end
    ackMode = 0;
    tick();
    @(negedge clk);
    checkOutput("drain_desc_left", 64'(expDesc.size()), 64'd0);
    checkOutput("drain_data_left", 64'(expData.size()), 64'd0);
    checkOutput("start_after_drain", 64'(bus.start), 64'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.rx_valid  = 1'b1;
    bus.rx_sop    = 1'b1;
    bus.rx_eop    = 1'b1;
    bus.rx_err    = 1'b0;
    bus.rx_data   = 32'h1234_5678;
    bus.rx_dest   = 3'd5;
    bus.fifo_full = 1'b0;
    bus.desc_ack  = 1'b1;

    // Reset: outputs low even with a beat and an ack presented.
    @(negedge clk);
    checkOutput("reset_rx_ready", 64'(bus.rx_ready), 64'd0);
    checkOutput("reset_fifo_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    checkOutput("reset_start", 64'(bus.start), 64'd0);
    checkOutput("reset_rx_out", 64'(bus.rx_out), 64'd0);
    checkOutput("reset_data_length", 64'(bus.data_length), 64'd0);
    checkOutput("reset_error_out", 64'(bus.error_out), 64'd0);
    tick();
    tick();
    rst_n        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_sop   = 1'b0;
    bus.rx_eop   = 1'b0;

    // 5-beat frame, dest 3, no stalls; start rises the cycle after COMMIT.
    wcStart = writeCount;
    applyStimulus(5, 3'd3, 1'b0, 1'b0, 0, 0, -1);
    @(negedge clk);
    checkOutput("start_low_in_commit", 64'(bus.start), 64'd0);
    tick();
    @(negedge clk);
    checkOutput("f5_start", 64'(bus.start), 64'd1);
    checkOutput("f5_rx_out", 64'(bus.rx_out), 64'd3);
    checkOutput("f5_data_length", 64'(bus.data_length), 64'd5);
    checkOutput("f5_error_out", 64'(bus.error_out), 64'd0);
    checkOutput("f5_writes", 64'(writeCount - wcStart), 64'd5);
    drain();

    // Beats without sop in IDLE are accepted and discarded.
    bus.rx_valid = 1'b1;
    bus.rx_sop   = 1'b0;
    bus.rx_eop   = 1'b1;
    bus.rx_data  = 32'hDEAD_0001;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("idle_nosop_ready", 64'(bus.rx_ready), 64'd1);
      checkOutput("idle_nosop_wr_en", 64'(bus.fifo_wr_en), 64'd0);
      tick();
    end
    bus.rx_valid = 1'b0;
    bus.rx_eop   = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("idle_nosop_start", 64'(bus.start), 64'd0);
    tick();

    // Single-beat frame.
    applyStimulus(1, 3'd1, 1'b0, 1'b0, 0, 0, -1);
    waitStart();
    checkOutput("single_data_length", 64'(bus.data_length), 64'd1);
    checkOutput("single_error_out", 64'(bus.error_out), 64'(RUNT_EN));
    drain();

    // fifo_full held three cycles mid-frame.
    wcStart = writeCount;
    applyStimulus(8, 3'd7, 1'b0, 1'b0, 0, 0, 3);
    waitStart();
    checkOutput("stall_data_length", 64'(bus.data_length), 64'd8);
    checkOutput("stall_writes", 64'(writeCount - wcStart), 64'd8);
    drain();

    // Longest legal frame, then an oversize frame that gets truncated.
    applyStimulus(63, 3'd2, 1'b0, 1'b0, 0, 0, -1);
    waitStart();
    checkOutput("max_data_length", 64'(bus.data_length), 64'd63);
    checkOutput("max_error_out", 64'(bus.error_out), 64'd0);
    drain();
    wcStart = writeCount;
    applyStimulus(70, 3'd4, 1'b0, 1'b0, 0, 0, -1);
    waitStart();
    checkOutput("long_data_length", 64'(bus.data_length), 64'd63);
    checkOutput("long_error_out", 64'(bus.error_out), 64'd1);
    checkOutput("long_writes", 64'(writeCount - wcStart), 64'd63);
    drain();

    // Four frames fill the queue; the fifth sop is held off until one ack.
    for (int f = 0; f < 4; f++) begin
      applyStimulus(f + 2, WS'(f), 1'b0, 1'b0, 0, 0, -1);
    end
    tick();
    bus.rx_valid = 1'b1;
    bus.rx_sop   = 1'b1;
    bus.rx_eop   = 1'b0;
    bus.rx_data  = 32'hBAD0_BAD0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("queue_full_ready", 64'(bus.rx_ready), 64'd0);
      checkOutput("queue_full_start", 64'(bus.start), 64'd1);
      tick();
    end
    bus.rx_valid = 1'b0;
    bus.rx_sop   = 1'b0;
    ackMode = 2;
    tick();
    ackMode = 0;
    tick();
    applyStimulus(3, 3'd4, 1'b0, 1'b0, 0, 0, -1);
    drain();

    // Reset during RECV with a descriptor already queued.
    applyStimulus(6, 3'd6, 1'b1, 1'b0, 0, 0, -1);
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.rx_valid  = 1'b1;
      bus.rx_sop    = (k == 0);
      bus.rx_eop    = 1'b0;
      bus.rx_data   = $urandom;
      bus.rx_dest   = 3'd5;
      bus.fifo_full = 1'b0;
      expData.push_back(bus.rx_data);
      @(negedge clk);
      checkOutput("partial_ready", 64'(bus.rx_ready), 64'd1);
      if (k == 0) checkOutput("pre_reset_rx_out", 64'(bus.rx_out), 64'd6);
      tick();
    end
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_rx_ready", 64'(bus.rx_ready), 64'd0);
    checkOutput("midreset_fifo_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    checkOutput("midreset_start", 64'(bus.start), 64'd0);
    checkOutput("midreset_rx_out", 64'(bus.rx_out), 64'd0);
    checkOutput("midreset_data_length", 64'(bus.data_length), 64'd0);
    checkOutput("midreset_error_out", 64'(bus.error_out), 64'd0);
    expDesc.delete();
    tick();
    rst_n        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_sop   = 1'b0;
    applyStimulus(4, 3'd2, 1'b0, 1'b0, 0, 0, -1);
    waitStart();
    checkOutput("post_reset_rx_out", 64'(bus.rx_out), 64'd2);
    checkOutput("post_reset_data_length", 64'(bus.data_length), 64'd4);
    checkOutput("post_reset_error_out", 64'(bus.error_out), 64'd0);
    drain();

    // Randomized frames with gaps, FIFO backpressure and random acks.
    ackMode = 1;
    for (int f = 0; f < 30; f++) begin
      int   n;
      logic e;
      bit   ms;
      n  = (f % 10 == 9) ? $urandom_range(60, 68) : $urandom_range(1, 14);
      e  = (n > 1) ? 1'($urandom_range(1)) : 1'b0;
      ms = (n >= 3) && (n <= MAXW) && ($urandom_range(3) == 0);
      applyStimulus(n, WS'($urandom), e, ms, 20, 15, -1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
